// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single RAM port served by ram_arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requesters plus the RAM itself.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that serializes two requesters onto one
// single-port synchronous RAM and routes registered read data back to the issuer.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              in_issue, in_resp;

    // NOTE: every next-state signal is given its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Contention goes to whoever did not win last; a lone requester always wins.
                    win_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = win_d;
                    we_d    = win_d ? bus.we1    : bus.we0;
                    addr_d  = win_d ? bus.addr1  : bus.addr0;
                    wdata_d = win_d ? bus.wdata1 : bus.wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE:  state_d = we_q ? IDLE : RDWAIT;
            RDWAIT: begin
                if (win_q) rdata1_d = bus.ram_rdata;
                else       rdata0_d = bus.ram_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes are gated by reset so a write sitting in ISSUE during reset never reaches the RAM.
    assign in_issue = (state_q == ISSUE) && !reset;
    assign in_resp  = (state_q == RESP)  && !reset;

    assign bus.ram_en    = in_issue;
    assign bus.ram_we    = in_issue && we_q;
    assign bus.ram_addr  = (state_q == ISSUE) ? addr_q  : '0;
    assign bus.ram_wdata = (state_q == ISSUE) ? wdata_q : '0;
    assign bus.gnt0      = in_issue && !win_q;
    assign bus.gnt1      = in_issue &&  win_q;
    assign bus.rvalid0   = in_resp  && !win_q;
    assign bus.rvalid1   = in_resp  &&  win_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
